// File: rtl/rs_syndrome_calc_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : rs_syndrome_calc_pkg
// Purpose: Shared RS(255,223) constants and GF(2^8) helper functions,
//          p(x) = x^8 + x^4 + x^3 + x^2 + 1 (0x11d). These are the same field
//          and root powers that the encoder uses.
// Contents: N, K, NSYM, PRIM_POLY, LAST_SLOT, gf2_8_add, gf2_8_mul, alpha_pow
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
package rs_syndrome_calc_pkg;

   localparam int          N         = 255;
   localparam int          K         = 223;
   localparam int          NSYM      = N - K;
   localparam logic [8:0]  PRIM_POLY = 9'h11d;
   localparam logic [7:0]  LAST_SLOT = 8'(N - 1);

   // Addition in GF(2^8) is a bitwise XOR.
   function automatic logic [7:0] gf2_8_add(input logic [7:0] a, input logic [7:0] b);
      return a ^ b;
   endfunction

   // Shift-and-reduce multiply. When one operand is a constant, synthesis
   // folds this function into a small fixed XOR network.
   function automatic logic [7:0] gf2_8_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ t;
         t = t[7] ? ((t << 1) ^ PRIM_POLY[7:0]) : (t << 1);
      end
      return p;
   endfunction

   // alpha^e with alpha = 0x02; this is evaluated only at elaboration time to
   // build the constant root powers ALPHA_POW_1..ALPHA_POW_32.
   function automatic logic [7:0] alpha_pow(input int e);
      logic [7:0] v;
      v = 8'h01;
      for (int i = 0; i < e; i++) v = gf2_8_mul(v, 8'h02);
      return v;
   endfunction

endpackage : rs_syndrome_calc_pkg
`default_nettype wire

// File: rtl/rs_synd_cell.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : rs_synd_cell
// Purpose: One syndrome accumulator. It evaluates r(x) at the constant root
//          COEF using Horner's rule, one symbol per enabled cycle.
// Ports  : clk, rst     clock and async active-high reset
//          i_en         symbol accepted this cycle
//          i_first      symbol is slot 0 (this restarts the evaluation)
//          i_data       received symbol
//          o_acc_next   next-state accumulator value (the value after this symbol)
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
module rs_synd_cell
   import rs_syndrome_calc_pkg::*;
#(
   parameter logic [7:0] COEF = 8'h02
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_en,
   input  logic       i_first,
   input  logic [7:0] i_data,
   output logic [7:0] o_acc_next
);

   logic [7:0] r_acc;
   logic [7:0] w_scaled;

   // Slot 0 discards the old value. Because of this, no explicit clear is
   // needed between frames.
   assign w_scaled   = i_first ? 8'h00 : gf2_8_mul(r_acc, COEF);
   assign o_acc_next = gf2_8_add(w_scaled, i_data);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       r_acc <= 8'h00;
      else if (i_en) r_acc <= o_acc_next;
   end

endmodule : rs_synd_cell
`default_nettype wire

// File: rtl/rs_syndrome_calc.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : rs_syndrome_calc
// Purpose: RS(255,223) syndrome calculator. It computes S_j = r(alpha^j) for
//          j = 1..32 over a stream of symbols ordered highest-degree first.
//          Each result bundle goes out over a valid/ready handshake.
// Ports  : clk, rst               clock, async active-high reset
//          din_valid/din_sof      input qualifier / first-symbol marker
//          data_in[7:0]           received symbol
//          synd_valid/synd_ready  output handshake
//          syndromes[255:0]       S_j in bits [8j-1:8j-8]
//          synd_err               any S_j non-zero (qualified by synd_valid)
//          overrun                pulse: a finished bundle was dropped
//          sync_err               pulse: din_sof arrived mid-frame
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
module rs_syndrome_calc
   import rs_syndrome_calc_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         din_valid,
   input  logic         din_sof,
   input  logic [7:0]   data_in,
   output logic         synd_valid,
   input  logic         synd_ready,
   output logic [255:0] syndromes,
   output logic         synd_err,
   output logic         overrun,
   output logic         sync_err
);

   logic [7:0]   r_cnt;
   logic [255:0] r_synd;
   logic         r_valid;
   logic         r_err;
   logic         r_overrun;
   logic         r_sync_err;

   logic [7:0]   w_slot;
   logic         w_first;
   logic         w_last;
   logic         w_sync;
   logic         w_load;
   logic         w_drop;
   logic [255:0] w_acc_next;

   // A qualified sof forces slot 0 regardless of the running count.
   assign w_slot  = (din_valid && din_sof) ? 8'd0 : r_cnt;
   assign w_first = (w_slot == 8'd0);
   assign w_last  = din_valid && (w_slot == LAST_SLOT);
   assign w_sync  = din_valid && din_sof && (r_cnt != 8'd0);

   // A completed frame loads the output register unless a bundle is still
   // being held. A handshake in the same cycle frees the register in time.
   assign w_load  = w_last && (!r_valid || synd_ready);
   assign w_drop  = w_last && r_valid && !synd_ready;

   genvar j;
   generate
      for (j = 1; j <= NSYM; j++) begin : g_cell
         rs_synd_cell #(
            .COEF (alpha_pow(j))
         ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .i_en       (din_valid),
            .i_first    (w_first),
            .i_data     (data_in),
            .o_acc_next (w_acc_next[8*j-1 -: 8])
         );
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt      <= 8'd0;
         r_synd     <= '0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
         r_overrun  <= 1'b0;
         r_sync_err <= 1'b0;
      end else begin
         if (din_valid)
            r_cnt <= (w_slot == LAST_SLOT) ? 8'd0 : w_slot + 8'd1;
         r_sync_err <= w_sync;
         r_overrun  <= w_drop;
         if (w_load) begin
            r_synd  <= w_acc_next;
            r_err   <= |w_acc_next;
            r_valid <= 1'b1;
         end else if (r_valid && synd_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign synd_valid = r_valid;
   assign syndromes  = r_synd;
   assign synd_err   = r_err;
   assign overrun    = r_overrun;
   assign sync_err   = r_sync_err;

endmodule : rs_syndrome_calc
`default_nettype wire

// File: tb/tb_rs_syndrome_calc.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module : tb_rs_syndrome_calc
// Purpose: Self-checking bench for rs_syndrome_calc. It uses log/antilog
//          table arithmetic, a systematic RS encoder, and a scoreboard of
//          expected bundles.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
module tb_rs_syndrome_calc;

   logic         clk = 1'b0;
   logic         rst;
   logic         din_valid;
   logic         din_sof;
   logic [7:0]   data_in;
   logic         synd_valid;
   logic         synd_ready;
   logic [255:0] syndromes;
   logic         synd_err;
   logic         overrun;
   logic         sync_err;

   rs_syndrome_calc dut (
      .clk        (clk),
      .rst        (rst),
      .din_valid  (din_valid),
      .din_sof    (din_sof),
      .data_in    (data_in),
      .synd_valid (synd_valid),
      .synd_ready (synd_ready),
      .syndromes  (syndromes),
      .synd_err   (synd_err),
      .overrun    (overrun),
      .sync_err   (sync_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [255:0] syn;
      logic         err;
   } exp_t;

   int          n_cmp  = 0;
   int          n_fail = 0;
   int          n_hs   = 0;
   int          n_ovr  = 0;
   int          n_sync = 0;
   logic [7:0]  gexp [0:254];
   int          glog [0:255];
   logic [7:0]  cw   [0:254];
   exp_t        sb_q [$];
   exp_t        held;
   int          hs0, ovr0, sync0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      if (a == 8'h00 || b == 8'h00) return 8'h00;
      return gexp[(glog[a] + glog[b]) % 255];
   endfunction

   // Direct evaluation: S_j = sum_k cw[k] * alpha^(j*(254-k))
   function automatic exp_t model();
      exp_t       e;
      logic [7:0] s;
      e.syn = '0;
      for (int jj = 1; jj <= 32; jj++) begin
         s = 8'h00;
         for (int k = 0; k < 255; k++)
            if (cw[k] != 8'h00) s ^= gexp[(glog[cw[k]] + jj * (254 - k)) % 255];
         e.syn[8*jj-1 -: 8] = s;
      end
      e.err = |e.syn;
      return e;
   endfunction

   // Systematic encoder: 223 random data symbols followed by 32 parity symbols
   task automatic make_codeword();
      logic [7:0] g [0:32];
      logic [7:0] p [0:31];
      logic [7:0] fb;
      for (int i = 0; i <= 32; i++) g[i] = 8'h00;
      g[0] = 8'h01;
      for (int r = 1; r <= 32; r++)
         for (int i = 32; i >= 0; i--)
            if (i == 0) g[0] = gmul(g[0], gexp[r]);
            else        g[i] = g[i-1] ^ gmul(g[i], gexp[r]);
      for (int i = 0; i < 32; i++) p[i] = 8'h00;
      for (int k = 0; k < 223; k++) begin
         cw[k] = 8'($urandom_range(255, 0));
         fb = cw[k] ^ p[31];
         for (int i = 31; i >= 1; i--) p[i] = p[i-1] ^ gmul(fb, g[i]);
         p[0] = gmul(fb, g[0]);
      end
      for (int i = 0; i < 32; i++) cw[223+i] = p[31-i];
   endtask

   task automatic zero_cw();
      for (int k = 0; k < 255; k++) cw[k] = 8'h00;
   endtask

   task automatic drive(input logic v, input logic sof, input logic [7:0] d);
      @(posedge clk); #1;
      din_valid = v;
      din_sof   = sof;
      data_in   = d;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 8'h00);
   endtask

   task automatic send_frame(input bit sof_first, input bit expect_out, input int gap_pct);
      exp_t e;
      for (int k = 0; k < 255; k++) begin
         if (gap_pct > 0 && int'($urandom_range(99, 0)) < gap_pct) drive(1'b0, 1'b0, 8'h00);
         drive(1'b1, sof_first && (k == 0), cw[k]);
      end
      if (expect_out) begin
         e = model();
         sb_q.push_back(e);
      end
   endtask

   // Monitor: a bundle is consumed when valid and ready are seen together
   always @(negedge clk) begin
      if (!rst) begin
         if (overrun)  n_ovr++;
         if (sync_err) n_sync++;
         if (synd_valid && synd_ready) begin
            exp_t e;
            n_hs++;
            n_cmp++;
            assert (sb_q.size() != 0) else begin
               n_fail++;
               $error("FAIL unexpected_bundle: got %0h expected none", syndromes);
            end
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               chk("bundle_syn", syndromes, e.syn);
               chk("bundle_err", 256'(synd_err), 256'(e.err));
            end
         end
      end
   end

   initial begin
      logic [7:0] ev;
      ev = 8'h01;
      for (int i = 0; i < 255; i++) begin
         gexp[i] = ev;
         glog[ev] = i;
         ev = ev[7] ? ((ev << 1) ^ 8'h1d) : (ev << 1);
      end
      glog[0] = 0;

      rst = 1'b1; din_valid = 1'b0; din_sof = 1'b0; data_in = 8'h00; synd_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid",    256'(synd_valid), 256'(0));
      chk("rst_syn",      syndromes, 256'(0));
      chk("rst_err",      256'(synd_err), 256'(0));
      chk("rst_overrun",  256'(overrun), 256'(0));
      chk("rst_sync_err", 256'(sync_err), 256'(0));
      @(posedge clk); #1; rst = 1'b0;

      // 1: all-zero codeword, latency of one cycle
      zero_cw();
      send_frame(1'b1, 1'b1, 0);
      chk("t1_valid_early", 256'(synd_valid), 256'(0));
      idle(1);
      chk("t1_valid_lat1", 256'(synd_valid), 256'(1));
      idle(3);
      chk("t1_valid_drop", 256'(synd_valid), 256'(0));

      // 2: encoder-produced codeword
      make_codeword();
      send_frame(1'b1, 1'b1, 0);
      idle(3);

      // 3: single error at r254, then single error at r0
      zero_cw(); cw[0] = 8'h01;
      send_frame(1'b1, 1'b1, 0);
      idle(1);
      chk("t3_s1_8e", 256'(syndromes[7:0]), 256'(8'h8e));
      chk("t3_err", 256'(synd_err), 256'(1));
      idle(3);
      zero_cw(); cw[254] = 8'h01;
      send_frame(1'b1, 1'b1, 0);
      idle(1);
      chk("t3_r0_all01", syndromes, {32{8'h01}});
      idle(3);

      // 4a: back-to-back frames with the bundle held -> overrun, one handshake
      hs0 = n_hs; ovr0 = n_ovr;
      synd_ready = 1'b0;
      make_codeword(); cw[10] ^= 8'h55;
      send_frame(1'b1, 1'b1, 0);
      held = sb_q[sb_q.size()-1];
      make_codeword(); cw[77] ^= 8'h3c;
      send_frame(1'b1, 1'b0, 0);
      idle(1);
      chk("t4_overrun_pulse", 256'(overrun), 256'(1));
      chk("t4_held_valid", 256'(synd_valid), 256'(1));
      chk("t4_held_syn", syndromes, held.syn);
      idle(10);
      chk("t4_held_after10", syndromes, held.syn);
      synd_ready = 1'b1;
      idle(4);
      chk("t4_one_handshake", 256'(n_hs - hs0), 256'(1));
      chk("t4_one_overrun", 256'(n_ovr - ovr0), 256'(1));
      chk("t4_valid_clear", 256'(synd_valid), 256'(0));

      // 4b: the same pair with ready high -> two bundles, no overrun
      hs0 = n_hs; ovr0 = n_ovr;
      make_codeword(); cw[3] ^= 8'h11;
      send_frame(1'b1, 1'b1, 0);
      make_codeword(); cw[200] ^= 8'h80;
      send_frame(1'b1, 1'b1, 0);
      idle(4);
      chk("t4b_two_handshakes", 256'(n_hs - hs0), 256'(2));
      chk("t4b_no_overrun", 256'(n_ovr - ovr0), 256'(0));

      // 5: sof at slot 100 aborts the partial frame
      hs0 = n_hs; sync0 = n_sync;
      for (int k = 0; k < 100; k++) drive(1'b1, k == 0, 8'($urandom_range(255, 0)));
      zero_cw();
      send_frame(1'b1, 1'b1, 0);
      idle(4);
      chk("t5_sync_once", 256'(n_sync - sync0), 256'(1));
      chk("t5_one_bundle", 256'(n_hs - hs0), 256'(1));

      // 6a: the r254 error pattern with random idle gaps
      hs0 = n_hs;
      zero_cw(); cw[0] = 8'h01;
      send_frame(1'b1, 1'b1, 30);
      idle(4);
      chk("t6a_one_bundle", 256'(n_hs - hs0), 256'(1));

      // 6b: reset at slot 50; the next frame is framed by the counter alone
      hs0 = n_hs;
      make_codeword();
      for (int k = 0; k < 50; k++) drive(1'b1, k == 0, cw[k]);
      @(posedge clk); #1; rst = 1'b1; din_valid = 1'b0; din_sof = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("t6b_rst_valid", 256'(synd_valid), 256'(0));
      chk("t6b_rst_syn", syndromes, 256'(0));
      @(posedge clk); #1; rst = 1'b0;
      zero_cw(); cw[0] = 8'h01;
      send_frame(1'b0, 1'b1, 0);
      idle(4);
      chk("t6b_one_bundle", 256'(n_hs - hs0), 256'(1));

      // Drain: every expected bundle must have been seen
      for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(negedge clk);
      chk("sb_drained", 256'(sb_q.size()), 256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_rs_syndrome_calc
`default_nettype wire
